// File: rtl/conv_mac_if.sv
// Product-in / result-out bundle between the multiplier, the window accumulator and its consumer.
interface conv_mac_if;
    logic        clr;
    logic [15:0] prod_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bias;
    logic [15:0] sum_out;
    logic        sat_flag;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output clr, prod_in, in_valid, bias, out_ready,
        input  in_ready, sum_out, sat_flag, out_valid
    );

    modport slave (
        input  clr, prod_in, in_valid, bias, out_ready,
        output in_ready, sum_out, sat_flag, out_valid
    );
endinterface

// File: rtl/conv_mac_accum.sv
// Accumulates KERNEL_N signed products onto a bias and emits the 16-bit saturated window sum.
// Optional build macro CONV_MAC_RELU_EN applies ReLU after saturation.
module conv_mac_accum #(
    parameter int KERNEL_N = 25,
    parameter int ACC_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    conv_mac_if.slave  bus
);
    localparam int CNT_W = $clog2(KERNEL_N + 1);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(KERNEL_N - 1);
    localparam logic signed [ACC_W-1:0] POS_LIM  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] NEG_LIM  = ~POS_LIM;

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]               sum_q, sum_d;
    logic                      sat_q, sat_d;
    logic                      out_valid_q, out_valid_d;

    logic                      beat;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [15:0]               res_val;
    logic                      res_sat;

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.sum_out   = sum_q;
    assign bus.sat_flag  = sat_q;
    assign bus.out_valid = out_valid_q;

    assign beat     = bus.in_valid && (state_q == S_ACC);
    // First beat of a window seeds the accumulator with the bias instead of the stale sum.
    assign acc_base = (cnt_q == '0) ? {{(ACC_W-16){bus.bias[15]}}, bus.bias} : acc_q;
    assign acc_sum  = acc_base + {{(ACC_W-16){bus.prod_in[15]}}, bus.prod_in};

    always_comb begin
        res_val = acc_sum[15:0];
        res_sat = 1'b0;
        if (acc_sum > POS_LIM) begin
            res_val = 16'h7fff;
            res_sat = 1'b1;
        end else if (acc_sum < NEG_LIM) begin
            res_val = 16'h8000;
            res_sat = 1'b1;
        end
`ifdef CONV_MAC_RELU_EN
        // sat_flag keeps reporting 16-bit clipping only; ReLU does not touch it.
        if (res_val[15]) begin
            res_val = 16'h0000;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        if (bus.clr) begin
            state_d     = S_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (beat) begin
                        acc_d = acc_sum;
                        if (cnt_q == LAST_CNT) begin
                            sum_d       = res_val;
                            sat_d       = res_sat;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = S_OUT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_ACC;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: a KERNEL_N=25 instance and a KERNEL_N=1 instance.
module tb_conv_mac_accum;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    conv_mac_if bus ();
    conv_mac_if bus1 ();

    conv_mac_accum #(.KERNEL_N(25), .ACC_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_mac_accum #(.KERNEL_N(1), .ACC_W(24)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CONV_MAC_RELU_EN
    localparam logic [15:0] NEG_SAT_EXP = 16'h0000;
    localparam logic [15:0] K1_EXP      = 16'h0000;
`else
    localparam logic [15:0] NEG_SAT_EXP = 16'h8000;
    localparam logic [15:0] K1_EXP      = 16'hffce;
`endif

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_window(input logic [15:0] b, input logic [15:0] p, input int n,
                               input int maxgap, output logic early);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (bus.out_valid) early = 1'b1;
            end
            bus.bias     = b;
            bus.prod_in  = p;
            bus.in_valid = 1'b1;
            tick();
            if (i < n - 1 && bus.out_valid) early = 1'b1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        else passed++;
        total++;
        if (bus.sum_out !== 16'h0000) $display("FAIL reset_sum_out got=%h want=0000", bus.sum_out);
        else passed++;
        total++;
        if (bus.sat_flag !== 1'b0) $display("FAIL reset_sat_flag got=%b want=0", bus.sat_flag);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        else passed++;
        $display("reset: out_valid=%b sum_out=%h in_ready=%b", bus.out_valid, bus.sum_out, bus.in_ready);
    endtask

    task automatic test_basic();
        logic early;
        send_window(16'd0, 16'd1024, 25, 0, early);
        total++;
        if (early !== 1'b0) $display("FAIL basic_early got=%b want=0", early);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b want=1", bus.out_valid);
        else passed++;
        total++;
        if (bus.sum_out !== 16'd25600) $display("FAIL basic_sum got=%0d want=25600", $signed(bus.sum_out));
        else passed++;
        total++;
        if (bus.sat_flag !== 1'b0) $display("FAIL basic_sat got=%b want=0", bus.sat_flag);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b0) $display("FAIL basic_in_ready got=%b want=0", bus.in_ready);
        else passed++;
        $display("basic: sum_out=%0d sat=%b", $signed(bus.sum_out), bus.sat_flag);
        pop();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL basic_pop got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        else passed++;
    endtask

    task automatic test_pos_sat();
        logic early;
        send_window(16'd16384, 16'd1024, 25, 0, early);
        total++;
        if (bus.out_valid !== 1'b1 || bus.sum_out !== 16'h7fff || bus.sat_flag !== 1'b1)
            $display("FAIL pos_sat got v=%b sum=%0d sat=%b want v=1 sum=32767 sat=1",
                     bus.out_valid, $signed(bus.sum_out), bus.sat_flag);
        else passed++;
        $display("pos_sat: sum_out=%0d sat=%b", $signed(bus.sum_out), bus.sat_flag);
        pop();
    endtask

    task automatic test_neg_sat();
        logic early;
        send_window(16'd0, 16'hf800, 25, 0, early);
        total++;
        if (bus.out_valid !== 1'b1 || bus.sum_out !== NEG_SAT_EXP || bus.sat_flag !== 1'b1)
            $display("FAIL neg_sat got v=%b sum=%h sat=%b want v=1 sum=%h sat=1",
                     bus.out_valid, bus.sum_out, bus.sat_flag, NEG_SAT_EXP);
        else passed++;
        $display("neg_sat: sum_out=%0d sat=%b", $signed(bus.sum_out), bus.sat_flag);
        pop();
    endtask

    task automatic test_backpressure();
        logic early;
        logic [15:0] held;
        send_window(16'd0, 16'd1024, 25, 0, early);
        held = bus.sum_out;
        bus.in_valid = 1'b1;
        bus.prod_in  = 16'd1000;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.sum_out !== 16'd25600 || bus.in_ready !== 1'b0)
                $display("FAIL stall_cycle%0d got v=%b sum=%0d rdy=%b want v=1 sum=25600 rdy=0",
                         c, bus.out_valid, $signed(bus.sum_out), bus.in_ready);
            else passed++;
        end
        total++;
        if (held !== 16'd25600) $display("FAIL stall_initial_sum got=%0d want=25600", $signed(held));
        else passed++;
        bus.in_valid = 1'b0;
        pop();
        send_window(16'd0, 16'd1, 25, 0, early);
        total++;
        if (early !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum_out !== 16'd25)
            $display("FAIL after_stall got early=%b v=%b sum=%0d want early=0 v=1 sum=25",
                     early, bus.out_valid, $signed(bus.sum_out));
        else passed++;
        $display("backpressure: next window sum_out=%0d", $signed(bus.sum_out));
        pop();
    endtask

    task automatic test_abort();
        logic early;
        logic seen;
        // Abort via clr, with a coincident beat that must be dropped.
        send_window(16'd0, 16'd1000, 10, 0, early);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.prod_in  = 16'd1000;
        tick();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        send_window(16'd0, 16'd1, 25, 0, seen);
        total++;
        if ((early | seen) !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum_out !== 16'd25)
            $display("FAIL abort_clr got early=%b v=%b sum=%0d want early=0 v=1 sum=25",
                     early | seen, bus.out_valid, $signed(bus.sum_out));
        else passed++;
        $display("abort_clr: sum_out=%0d", $signed(bus.sum_out));
        // clr while a result is waiting drops it.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL clr_in_out got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        else passed++;
        // Abort via rst mid-window.
        send_window(16'd0, 16'd1000, 10, 0, early);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.sum_out !== 16'h0000 || bus.out_valid !== 1'b0)
            $display("FAIL abort_rst_state got sum=%h v=%b want 0000/0", bus.sum_out, bus.out_valid);
        else passed++;
        send_window(16'd0, 16'd1, 25, 0, seen);
        total++;
        if ((early | seen) !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum_out !== 16'd25)
            $display("FAIL abort_rst got early=%b v=%b sum=%0d want early=0 v=1 sum=25",
                     early | seen, bus.out_valid, $signed(bus.sum_out));
        else passed++;
        $display("abort_rst: sum_out=%0d", $signed(bus.sum_out));
        pop();
    endtask

    task automatic test_gapped();
        logic early;
        send_window(16'd0, 16'd1024, 25, 3, early);
        total++;
        if (early !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum_out !== 16'd25600 || bus.sat_flag !== 1'b0)
            $display("FAIL gapped got early=%b v=%b sum=%0d sat=%b want 0/1/25600/0",
                     early, bus.out_valid, $signed(bus.sum_out), bus.sat_flag);
        else passed++;
        $display("gapped: sum_out=%0d", $signed(bus.sum_out));
        pop();
    endtask

    task automatic test_kernel1();
        logic [15:0] prods [3];
        prods[0] = 16'd10;
        prods[1] = 16'd20;
        prods[2] = 16'd30;
        bus1.bias     = 16'hff9c;
        bus1.prod_in  = 16'd50;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        total++;
        if (bus1.out_valid !== 1'b1 || bus1.sum_out !== K1_EXP || bus1.sat_flag !== 1'b0)
            $display("FAIL k1_single got v=%b sum=%h sat=%b want v=1 sum=%h sat=0",
                     bus1.out_valid, bus1.sum_out, bus1.sat_flag, K1_EXP);
        else passed++;
        $display("k1_single: sum_out=%0d", $signed(bus1.sum_out));
        bus1.out_ready = 1'b1;
        tick();
        // Back-to-back: in_valid and out_ready held high give one window every two cycles.
        bus1.bias     = 16'd0;
        bus1.in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            bus1.prod_in = prods[w];
            tick();
            total++;
            if (bus1.out_valid !== 1'b1 || bus1.sum_out !== prods[w])
                $display("FAIL k1_b2b_out%0d got v=%b sum=%0d want v=1 sum=%0d",
                         w, bus1.out_valid, $signed(bus1.sum_out), prods[w]);
            else passed++;
            tick();
            total++;
            if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
                $display("FAIL k1_b2b_gap%0d got v=%b rdy=%b want 0/1", w, bus1.out_valid, bus1.in_ready);
            else passed++;
            $display("k1_b2b window %0d: sum_out=%0d", w, $signed(bus1.sum_out));
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        bus.clr = 1'b0;  bus.prod_in = '0;  bus.in_valid = 1'b0;  bus.bias = '0;  bus.out_ready = 1'b0;
        bus1.clr = 1'b0; bus1.prod_in = '0; bus1.in_valid = 1'b0; bus1.bias = '0; bus1.out_ready = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_backpressure();
        test_abort();
        test_gapped();
        test_kernel1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
